// File: rtl/clock_top_if.sv
// Button inputs and multiplexed display outputs of the clock, bundled for
// testbench and board-level wiring; the core keeps its flat port list.
interface clock_top_if;
    logic       i_Button_Set;
    logic       i_Button_Up;
    logic [7:0] o_Segments;
    logic [3:0] o_Digits;

    modport master (output i_Button_Set, output i_Button_Up,
                    input  o_Segments,   input  o_Digits);
    modport slave  (input  i_Button_Set, input  i_Button_Up,
                    output o_Segments,   output o_Digits);
endinterface

// File: rtl/clock_top.sv
// HH:MM wall clock with Set/Up buttons and a 4-digit multiplexed 7-segment
// display; a 1 Hz dot blinks while the clock is running.
module clock_top #(
    parameter int PRESCALE = 32768,
    parameter int DEBOUNCE = 512,
    parameter int SCAN     = 256
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Button_Set,
    input  logic       i_Button_Up,
    output logic [7:0] o_Segments,
    output logic [3:0] o_Digits
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int SW = $clog2(SCAN);

    localparam logic [1:0] NORMAL    = 2'd0;
    localparam logic [1:0] RESET_SEC = 2'd1;
    localparam logic [1:0] SET_MIN   = 2'd2;
    localparam logic [1:0] SET_HOUR  = 2'd3;

    // Index 0 = Set button, index 1 = Up button
    logic [1:0]    r_Sync1;
    logic [1:0]    r_Sync2;
    logic [1:0]    r_Deb;
    logic [DW-1:0] r_DebCnt [2];
    logic [1:0]    w_Flip;
    logic [1:0]    w_Press;
    logic          w_Set;
    logic          w_Up;

    logic [1:0]    r_Mode;
    logic [PW-1:0] r_Pre;
    logic          w_Tick;
    logic [5:0]    r_Sec;
    logic [2:0]    r_Min_T;
    logic [3:0]    r_Min_U;
    logic [1:0]    r_Hour_T;
    logic [3:0]    r_Hour_U;
    logic          w_Min_Max;
    logic          w_Hour_Max;
    logic          w_Min_Inc;
    logic          w_Hour_Inc;

    logic [SW-1:0] r_Scan;
    logic [1:0]    r_Pos;
    logic [3:0]    w_Digit;
    logic [3:0]    w_Mask;
    logic [3:0]    w_Onehot;
    logic [6:0]    w_Seg7;
    logic          w_Dot;

    assign w_Flip[0]  = (r_Sync2[0] != r_Deb[0]) && (r_DebCnt[0] == DW'(DEBOUNCE - 1));
    assign w_Flip[1]  = (r_Sync2[1] != r_Deb[1]) && (r_DebCnt[1] == DW'(DEBOUNCE - 1));
    assign w_Press    = w_Flip & r_Sync2;
    assign w_Set      = w_Press[0];
    assign w_Up       = w_Press[1] & ~w_Press[0];

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Sync1 <= '0;
            r_Sync2 <= '0;
            r_Deb   <= '0;
            for (int unsigned k = 0; k < 2; k++) r_DebCnt[k] <= '0;
        end else begin
            r_Sync1 <= {i_Button_Up, i_Button_Set};
            r_Sync2 <= r_Sync1;
            for (int unsigned k = 0; k < 2; k++) begin
                if (r_Sync2[k] == r_Deb[k]) begin
                    r_DebCnt[k] <= '0;
                end else if (w_Flip[k]) begin
                    r_Deb[k]    <= r_Sync2[k];
                    r_DebCnt[k] <= '0;
                end else begin
                    r_DebCnt[k] <= r_DebCnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Mode <= NORMAL;
        end else if (w_Set) begin
            case (r_Mode)
                NORMAL:    r_Mode <= RESET_SEC;
                RESET_SEC: r_Mode <= SET_MIN;
                SET_MIN:   r_Mode <= SET_HOUR;
                default:   r_Mode <= NORMAL;
            endcase
        end
    end

    assign w_Tick     = (r_Mode == NORMAL) && (r_Pre == PW'(PRESCALE - 1));
    assign w_Min_Max  = (r_Min_T == 3'd5) && (r_Min_U == 4'd9);
    assign w_Hour_Max = (r_Hour_T == 2'd2) && (r_Hour_U == 4'd3);
    // Ticks only occur in NORMAL and Up only acts in the set modes, so the
    // carry and manual increment paths never coincide.
    assign w_Min_Inc  = (w_Tick && r_Sec == 6'd59) || (w_Up && r_Mode == SET_MIN);
    assign w_Hour_Inc = (w_Tick && r_Sec == 6'd59 && w_Min_Max) ||
                        (w_Up && r_Mode == SET_HOUR);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Pre <= '0;
            r_Sec <= '0;
        end else if (r_Mode == RESET_SEC) begin
            r_Pre <= '0;
            r_Sec <= '0;
        end else if (r_Mode == NORMAL) begin
            r_Pre <= w_Tick ? '0 : r_Pre + 1'b1;
            if (w_Tick) r_Sec <= (r_Sec == 6'd59) ? '0 : r_Sec + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Min_T  <= '0;
            r_Min_U  <= '0;
            r_Hour_T <= '0;
            r_Hour_U <= '0;
        end else begin
            if (w_Min_Inc) begin
                if (r_Min_U == 4'd9) begin
                    r_Min_U <= '0;
                    r_Min_T <= (r_Min_T == 3'd5) ? '0 : r_Min_T + 1'b1;
                end else begin
                    r_Min_U <= r_Min_U + 1'b1;
                end
            end
            if (w_Hour_Inc) begin
                if (w_Hour_Max) begin
                    r_Hour_T <= '0;
                    r_Hour_U <= '0;
                end else if (r_Hour_U == 4'd9) begin
                    r_Hour_U <= '0;
                    r_Hour_T <= r_Hour_T + 1'b1;
                end else begin
                    r_Hour_U <= r_Hour_U + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Scan <= '0;
            r_Pos  <= '0;
        end else if (r_Scan == SW'(SCAN - 1)) begin
            r_Scan <= '0;
            r_Pos  <= r_Pos + 1'b1;
        end else begin
            r_Scan <= r_Scan + 1'b1;
        end
    end

    always_comb begin
        w_Digit = '0;
        case (r_Pos)
            2'd0:    w_Digit = {2'b00, r_Hour_T};
            2'd1:    w_Digit = r_Hour_U;
            2'd2:    w_Digit = {1'b0, r_Min_T};
            default: w_Digit = r_Min_U;
        endcase
    end

    always_comb begin
        w_Seg7 = '0;
        case (w_Digit)
            4'd0:    w_Seg7 = 7'b0111111;
            4'd1:    w_Seg7 = 7'b0000110;
            4'd2:    w_Seg7 = 7'b1011011;
            4'd3:    w_Seg7 = 7'b1001111;
            4'd4:    w_Seg7 = 7'b1100110;
            4'd5:    w_Seg7 = 7'b1101101;
            4'd6:    w_Seg7 = 7'b1111101;
            4'd7:    w_Seg7 = 7'b0000111;
            4'd8:    w_Seg7 = 7'b1111111;
            4'd9:    w_Seg7 = 7'b1101111;
            default: w_Seg7 = '0;
        endcase
    end

    always_comb begin
        w_Mask = '0;
        case (r_Mode)
            NORMAL:    w_Mask = 4'b1111;
            RESET_SEC: w_Mask = 4'b0000;
            SET_MIN:   w_Mask = 4'b1100;
            default:   w_Mask = 4'b0011;
        endcase
    end

    assign w_Onehot = 4'b0001 << r_Pos;
    assign w_Dot    = (r_Mode == NORMAL) && (r_Pre < PW'(PRESCALE / 2));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Digits   <= 4'b0001;
            o_Segments <= 8'b1011_1111;
        end else begin
            o_Digits   <= w_Onehot & w_Mask;
            o_Segments <= {w_Dot, w_Seg7};
        end
    end
endmodule

// File: tb/tb_clock_top.sv
// Scoreboard bench: full-rate instance for timing/debounce, a fast-parameter
// instance for the 23:59:59 rollover and minute wrap.
module tb_clock_top;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_top_if bus_a ();
    clock_top_if bus_b ();

    clock_top dut_a (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Button_Set (bus_a.i_Button_Set),
        .i_Button_Up  (bus_a.i_Button_Up),
        .o_Segments   (bus_a.o_Segments),
        .o_Digits     (bus_a.o_Digits)
    );

    clock_top #(.PRESCALE(16), .DEBOUNCE(4), .SCAN(2)) dut_b (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Button_Set (bus_b.i_Button_Set),
        .i_Button_Up  (bus_b.i_Button_Up),
        .o_Segments   (bus_b.o_Segments),
        .o_Digits     (bus_b.o_Digits)
    );

    // Posedges since reset release; also models the free-running scan slot
    int n = 0;
    always @(posedge clk) begin
        if (!rst_n) n = 0;
        else        n = n + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [11:0] val;
        logic [11:0] msk;
    } exp_t;
    exp_t sb[$];

    int mode_m [2];
    int hh     [2];
    int mm     [2];
    bit dot_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input int m);
        case (m)
            0: return 4'b1111;
            1: return 4'b0000;
            2: return 4'b1100;
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic [11:0] observe(input int w);
        if (w != 0) return {bus_b.o_Digits, bus_b.o_Segments};
        return {bus_a.o_Digits, bus_a.o_Segments};
    endfunction

    // Push the frame expected after posedge t, then sample and pop it
    task automatic check_at(input int w, input string tag, input int t);
        int scan;
        int p;
        int d;
        int g;
        logic [3:0] dig;
        logic dot;
        logic known;
        exp_t e;
        logic [11:0] obs;
        scan = (w != 0) ? 2 : 256;
        p = ((t - 1) / scan) % 4;
        case (p)
            0: d = hh[w] / 10;
            1: d = hh[w] % 10;
            2: d = mm[w] / 10;
            default: d = mm[w] % 10;
        endcase
        dig = (4'b0001 << p) & mask_of(mode_m[w]);
        if (mode_m[w] != 0) begin
            dot = 1'b0; known = 1'b1;
        end else if (w == 0 && dot_ok) begin
            dot = (((t - 1) % 32768) < 16384); known = 1'b1;
        end else begin
            dot = 1'b0; known = 1'b0;
        end
        e.tag = tag;
        e.val = {dig, dot, seg7(d)};
        e.msk = known ? 12'hFFF : 12'hF7F;
        sb.push_back(e);
        g = 0;
        while (n < t && g < t + 10) begin
            @(negedge clk);
            g++;
        end
        if (n != t) check({tag, "_timeout"}, 32'(n), 32'(t));
        e = sb.pop_front();
        obs = observe(w);
        check(e.tag, 32'(obs & e.msk), 32'(e.val & e.msk));
    endtask

    task automatic check_slot(input int w, input string tag, input int p);
        int scan;
        int t;
        int g;
        scan = (w != 0) ? 2 : 256;
        t = n + 1;
        g = 0;
        while (!(((t - 1) % scan) == scan / 2 && ((t - 1) / scan) % 4 == p) && g < 5 * scan) begin
            t++;
            g++;
        end
        check_at(w, tag, t);
    endtask

    task automatic check_rst(input string tag);
        exp_t e;
        for (int w = 0; w < 2; w++) begin
            e.tag = tag;
            e.val = 12'b0001_1011_1111;
            e.msk = 12'hFFF;
            sb.push_back(e);
        end
        for (int w = 0; w < 2; w++) begin
            e = sb.pop_front();
            check(e.tag, 32'(observe(w)), 32'(e.val));
        end
    endtask

    task automatic drive(input int w, input bit s, input bit u, input int cycles);
        if (w != 0) begin
            bus_b.i_Button_Set = s;
            bus_b.i_Button_Up  = u;
        end else begin
            bus_a.i_Button_Set = s;
            bus_a.i_Button_Up  = u;
        end
        repeat (cycles) @(negedge clk);
    endtask

    task automatic advance_mode(input int w);
        mode_m[w] = (mode_m[w] + 1) % 4;
        if (w == 0) dot_ok = 1'b0;
    endtask

    task automatic press(input int w, input bit s, input bit u);
        int on_c;
        int off_c;
        on_c  = (w != 0) ? 16 : 1024;
        off_c = (w != 0) ? 16 : 600;
        drive(w, s, u, on_c);
        drive(w, 1'b0, 1'b0, off_c);
        if (s) begin
            advance_mode(w);
        end else if (u) begin
            if (mode_m[w] == 2) mm[w] = (mm[w] + 1) % 60;
            if (mode_m[w] == 3) hh[w] = (hh[w] + 1) % 24;
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            mode_m[w] = 0;
            hh[w] = 0;
            mm[w] = 0;
        end
        dot_ok = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        bus_a.i_Button_Set = 1'b0;
        bus_a.i_Button_Up  = 1'b0;
        bus_b.i_Button_Set = 1'b0;
        bus_b.i_Button_Up  = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_rst("reset_outputs");
        rst_n = 1'b1;

        // Free-running second
        check_at(0, "slot0_start", 128);
        check_slot(0, "slot3_start", 3);
        check_at(0, "dot_low_half", 20000);
        check_at(0, "pre_last", 32767);
        check("sec_before_tick", 32'(dut_a.r_Sec), 32'd0);
        check_at(0, "tick_edge", 32768);
        check_at(0, "second_start_dot", 32769);
        check("sec_after_tick", 32'(dut_a.r_Sec), 32'd1);

        // Mode walk with minute/hour setting
        press(0, 1'b1, 1'b0);
        check_slot(0, "rsec_slot0", 0);
        check_slot(0, "rsec_slot3", 3);
        check("rsec_sec_zero", 32'(dut_a.r_Sec), 32'd0);
        press(0, 1'b1, 1'b0);
        check_slot(0, "setmin_slot3", 3);
        check_slot(0, "setmin_slot0", 0);
        press(0, 1'b0, 1'b1);
        press(0, 1'b0, 1'b1);
        check_slot(0, "setmin_up2", 3);
        press(0, 1'b1, 1'b0);
        press(0, 1'b0, 1'b1);
        check_slot(0, "sethour_up1", 1);
        check_slot(0, "sethour_slot3", 3);
        press(0, 1'b1, 1'b0);
        check_slot(0, "normal_mm", 3);
        check_slot(0, "normal_hh", 1);

        // Bouncing Set yields a single advance; short glitches yield none
        drive(0, 1'b1, 1'b0, 5);
        drive(0, 1'b0, 1'b0, 3);
        drive(0, 1'b1, 1'b0, 2);
        drive(0, 1'b0, 1'b0, 1);
        drive(0, 1'b1, 1'b0, 1024);
        drive(0, 1'b0, 1'b0, 600);
        advance_mode(0);
        check_slot(0, "bounce_slot3", 3);
        check_slot(0, "bounce_slot0", 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 1'b0, 10);
            drive(0, 1'b0, 1'b0, 20);
        end
        drive(0, 1'b0, 1'b0, 600);
        check_slot(0, "glitch_slot3", 3);
        check_slot(0, "glitch_slot1", 1);

        // Simultaneous Set+Up: mode advances, minutes untouched
        press(0, 1'b1, 1'b0);
        press(0, 1'b1, 1'b1);
        check_slot(0, "both_hh", 1);
        check_slot(0, "both_mm", 3);

        // Reset while in a setting mode
        rst_n = 1'b0;
        #1;
        check_rst("midop_reset");
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check_at(0, "post_reset_slot0", 128);
        check_slot(0, "post_reset_slot3", 3);

        // Fast instance: Up ignored in NORMAL, minute wrap, day rollover
        press(1, 1'b0, 1'b1);
        check_slot(1, "b_up_normal", 3);
        press(1, 1'b1, 1'b0);
        press(1, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) press(1, 1'b0, 1'b1);
        check_slot(1, "b_mm59_tens", 2);
        check_slot(1, "b_mm59_units", 3);
        press(1, 1'b0, 1'b1);
        check_slot(1, "b_mm_wrap", 3);
        check_slot(1, "b_mm_wrap_hh", 1);
        for (int i = 0; i < 59; i++) press(1, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) press(1, 1'b0, 1'b1);
        check_slot(1, "b_hh23_tens", 0);
        check_slot(1, "b_hh23_units", 1);
        check_slot(1, "b_hh23_mm", 3);
        press(1, 1'b1, 1'b0);
        g = 0;
        while (dut_b.r_Sec != 6'd59 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("b_sec59_reached", 32'(dut_b.r_Sec), 32'd59);
        g = 0;
        while (dut_b.r_Sec == 6'd59 && g < 40) begin
            @(negedge clk);
            g++;
        end
        hh[1] = 0;
        mm[1] = 0;
        check("b_sec_wrap", 32'(dut_b.r_Sec), 32'd0);
        for (int p = 0; p < 4; p++) check_slot(1, $sformatf("b_midnight_slot%0d", p), p);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_top.md
CLOCK_TOP -- requirements
Module: clock_top

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port i_Clock: input, 1 bit; sole clock, 32.768 kHz nominal, rising-edge.
REQ-003 Port i_Reset_n: input, 1 bit; asynchronous, active-low reset.
REQ-004 Port i_Button_Set: input, 1 bit; raw asynchronous mode button, active-high.
REQ-005 Port i_Button_Up: input, 1 bit; raw asynchronous increment button, active-high.
REQ-006 Port o_Segments: output, 8 bits, active-high; bit7 = dot, bits6:0 = g,f,e,d,c,b,a.
REQ-007 Port o_Digits: output, 4 bits, active-high digit enables; bit0 = hours tens, bit1 = hours units, bit2 = minutes tens, bit3 = minutes units.
REQ-008 Parameters: PRESCALE = 32768 (cycles per second), DEBOUNCE = 512 (stable cycles), SCAN = 256 (cycles per digit slot).

Function
REQ-009 Each button SHALL pass through a 2-FF synchronizer, then a debouncer.
- The debounced state changes only after DEBOUNCE consecutive equal synchronized samples.
- A "press" is a 1-cycle pulse on the debounced 0->1 edge.
- Pulses shorter than DEBOUNCE cycles SHALL produce no press.
REQ-010 The mode FSM SHALL have states NORMAL, RESET_SEC, SET_MIN and SET_HOUR.
- Each Set press advances NORMAL->RESET_SEC->SET_MIN->SET_HOUR->NORMAL.
REQ-011 The prescaler SHALL count 0..PRESCALE-1 in NORMAL and emit a 1-cycle tick when it wraps to 0.
REQ-012 On a tick, seconds SHALL count 0..59 and carry into minutes.
- Minutes count 0..59 and carry into hours.
- Hours count 0..23; 23:59:59 wraps to 00:00:00.
REQ-013 In RESET_SEC, the seconds and prescaler SHALL be forced to 0 and held there; minutes and hours are held.
REQ-014 In SET_MIN and SET_HOUR, the prescaler and seconds SHALL be frozen.
REQ-015 An Up press SHALL have the following effect per mode:
- SET_MIN: minutes +1, 59->0, no carry into hours.
- SET_HOUR: hours +1, 23->0.
- NORMAL and RESET_SEC: ignored.
REQ-016 If Set and Up presses occur in the same cycle, Set SHALL be applied and Up discarded.
REQ-017 A free-running scan counter SHALL select the digit slot pos = 0..3, advancing every SCAN cycles and wrapping 3->0.
REQ-018 o_Digits SHALL equal onehot(pos) AND the mode mask. Mode masks:
- NORMAL: 1111.
- RESET_SEC: 0000 (display blank).
- SET_MIN: 1100.
- SET_HOUR: 0011.
REQ-019 o_Segments[6:0] SHALL show the BCD digit for slot pos using these patterns:
- 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
- 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
REQ-020 o_Segments[7] (dot) SHALL be 1 only in NORMAL while prescaler < PRESCALE/2, giving a 1 Hz blink; it is 0 in all other modes.
REQ-021 All outputs SHALL be registered, with a latency of 1 cycle from the counter and state registers.

Reset
REQ-022 While i_Reset_n = 0, the block SHALL immediately clear the following:
- time 00:00:00;
- prescaler, scan counter and debouncers (debounced state 0);
- mode NORMAL.
REQ-023 The reset values of the outputs SHALL be o_Digits = 0001 and o_Segments = 10111111.
REQ-024 A reset asserted mid-operation, including during a setting mode, SHALL abort to the reset state with no press generated on release.

Verification
REQ-025 Release reset, sample during slot 0 -> o_Digits = 0001, o_Segments = 10111111.
REQ-026 Run 32768 cycles in NORMAL -> seconds = 1, minutes and hours unchanged; dot = 1 again at the start of the second.
REQ-027 Send four 1024-cycle Set presses -> mode sequence RESET_SEC (o_Digits = 0000), SET_MIN (mask 1100), SET_HOUR (mask 0011), NORMAL.
REQ-028 In SET_MIN, send 2 Up presses -> minutes-units slot shows 1011011 (2); then Set, then 1 Up -> hours-units slot shows 0000110 (1), dot = 0.
REQ-029 Send a bouncing Set (5 on / 3 off / 2 on / 1 off, then stable 1024) -> exactly one mode advance.
- Then send five 10-cycle Set pulses -> no mode change.
REQ-030 Preset 23:59:59 and wait for 1 tick -> 00:00:00.
- In SET_MIN at 59, send Up -> minutes = 00, hours unchanged.
